// File: rtl/ste_disp_bcd.sv
// ste_disp_bcd: captures an averaged binary value on its update strobe and
// converts it to packed BCD with a one-bit-per-clock double-dabble engine.
// Supports display hold, synchronous clear, and a one-deep pending slot for
// updates that arrive while a conversion is in flight.
module ste_disp_bcd #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din_i,
    input  logic                  din_update_i,
    input  logic                  hold_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid_o,
    output logic                  busy_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned CAT_W = BCD_W + DATA_W;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Reject parameter sets the engine cannot represent.
    if (DATA_W < 4 || DATA_W > 20) begin : g_bad_width
        $error("ste_disp_bcd: DATA_W must be within 4..20");
    end
    if (DIGITS > 19 || pow10(DIGITS) <= ((64'd1 << DATA_W) - 64'd1)) begin : g_bad_digits
        $error("ste_disp_bcd: DIGITS too small for DATA_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic [CAT_W-1:0]   dd_next;

    // Add 3 to every BCD digit that is 5 or more before the next shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        accept     = din_update_i && !hold_i;
        dd_next    = {add3(scratch_q), shift_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = din_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shift_d} = dd_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
                if (accept) begin
                    pend_d     = din_i;
                    pend_vld_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!hold_i) begin
                    bcd_d   = scratch_q;
                    valid_d = 1'b1;
                end
                // A same-cycle update is the newest pending value, so it is
                // consumed straight away instead of passing through pend_q.
                if (accept) begin
                    shift_d    = din_i;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else if (pend_vld_q) begin
                    shift_d    = pend_q;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clr_i) begin
            state_d    = ST_IDLE;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            bcd_d      = '0;
            valid_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ste_disp_bcd.sv
// Testbench for ste_disp_bcd: table-driven single conversions, hand-written
// sequences for chaining, hold, clear and asynchronous reset, and a sweep
// against a decimal reference.
module tb_ste_disp_bcd;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        upd;
    logic        hold;
    logic        clr;
    logic [19:0] bcd;
    logic        valid;
    logic        busy;

    int n_checks;
    int n_fail;

    ste_disp_bcd #(.DATA_W(16), .DIGITS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_i        (din),
        .din_update_i (upd),
        .hold_i       (hold),
        .clr_i        (clr),
        .bcd_o        (bcd),
        .bcd_valid_o  (valid),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [19:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] bcd_ref(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Strobe one value while idle and check latency, result and pulse width.
    task automatic do_conv(input logic [15:0] v, input logic [19:0] exp, input string nm);
        int n;
        din = v;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_latency"}, n, 17);
        check({nm, "_bcd"}, 32'(bcd), 32'(exp));
        tick();
        check({nm, "_vdrop"}, 32'(valid), 32'd0);
    endtask

    vec_t vecs[5];
    int   pulses;
    int   busy_bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        din   = '0;
        upd   = 1'b0;
        hold  = 1'b0;
        clr   = 1'b0;

        vecs[0] = '{16'd12345, 20'h12345};
        vecs[1] = '{16'd0,     20'h00000};
        vecs[2] = '{16'd65535, 20'h65535};
        vecs[3] = '{16'd9,     20'h00009};
        vecs[4] = '{16'd10,    20'h00010};

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_conv(vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back: 100 @0, 200 @3, 300 @5.
        din = 16'd100;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        pulses   = 0;
        busy_bad = 0;
        for (int e = 1; e <= 40; e++) begin
            upd = (e == 3 || e == 5);
            din = (e == 3) ? 16'd200 : 16'd300;
            tick();
            upd = 1'b0;
            if (valid) pulses++;
            if (e < 34 && !busy) busy_bad++;
            if (e == 17) begin
                check("b2b_v17", 32'(valid), 32'd1);
                check("b2b_bcd17", 32'(bcd), 32'h00100);
            end
            if (e == 34) begin
                check("b2b_v34", 32'(valid), 32'd1);
                check("b2b_bcd34", 32'(bcd), 32'h00300);
                check("b2b_busy34", 32'(busy), 32'd0);
            end
        end
        check("b2b_pulses", pulses, 2);
        check("b2b_busy_gap", busy_bad, 0);

        // Hold while idle, then hold rising mid-conversion.
        do_conv(16'd42, 20'h00042, "h42");
        hold = 1'b1;
        din  = 16'd777;
        upd  = 1'b1;
        tick();
        upd = 1'b0;
        check("hold_idle_busy", 32'(busy), 32'd0);
        pulses   = 0;
        busy_bad = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (valid) pulses++;
            if (busy) busy_bad++;
        end
        check("hold_idle_pulses", pulses, 0);
        check("hold_idle_busy_seen", busy_bad, 0);
        check("hold_idle_bcd", 32'(bcd), 32'h00042);
        hold = 1'b0;
        din  = 16'd1234;
        upd  = 1'b1;
        tick();
        upd    = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 25; e++) begin
            hold = (e >= 10);
            tick();
            if (valid) pulses++;
        end
        check("hold_mid_pulses", pulses, 0);
        check("hold_mid_bcd", 32'(bcd), 32'h00042);
        check("hold_mid_busy", 32'(busy), 32'd0);
        hold = 1'b0;
        tick();
        do_conv(16'd777, 20'h00777, "h777");

        // Clear at cycle 8 with 6000 pending and a simultaneous 7000 strobe.
        din = 16'd5000;
        upd = 1'b1;
        tick();
        for (int e = 1; e <= 7; e++) begin
            upd = (e == 3);
            din = 16'd6000;
            tick();
        end
        clr = 1'b1;
        upd = 1'b1;
        din = 16'd7000;
        tick();
        clr = 1'b0;
        upd = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_bcd", 32'(bcd), 32'd0);
        check("clr_valid", 32'(valid), 32'd0);
        pulses   = 0;
        busy_bad = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (valid) pulses++;
            if (busy) busy_bad++;
        end
        check("clr_pulses", pulses, 0);
        check("clr_busy_seen", busy_bad, 0);

        // Asynchronous reset at cycle 9 of a conversion.
        do_conv(16'd55, 20'h00055, "r55");
        din = 16'd999;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_bcd", 32'(bcd), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (valid) pulses++;
        end
        check("arst_pulses", pulses, 0);
        do_conv(16'd31, 20'h00031, "r31");

        // Sweep: low range sequentially plus scattered values.
        for (int unsigned v = 0; v < 600; v++) begin
            do_conv(16'(v), bcd_ref(v), $sformatf("sw%0d", v));
        end
        for (int i = 0; i < 400; i++) begin
            int unsigned v;
            v = $urandom_range(65535, 0);
            do_conv(16'(v), bcd_ref(v), $sformatf("rnd%0d", v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
